// File: rtl/video_vga_dbl_if.sv
// video_vga_dbl_if: pixel strobes, TV line/colour input and doubled VGA output of the scan doubler.
interface video_vga_dbl_if;
  logic       wr_stb;
  logic       rd_stb;
  logic       line_start;
  logic       vsync_in;
  logic [5:0] color_in;
  logic [5:0] vga_color;
  logic       vga_hsync;
  logic       vga_vsync;
  logic       vga_pass;
  modport master (
    output wr_stb, rd_stb, line_start, vsync_in, color_in,
    input  vga_color, vga_hsync, vga_vsync, vga_pass
  );
  modport slave (
    input  wr_stb, rd_stb, line_start, vsync_in, color_in,
    output vga_color, vga_hsync, vga_vsync, vga_pass
  );
endinterface

// File: rtl/video_vga_dbl.sv
// video_vga_dbl: VGA scan doubler; captures each TV line into a ping-pong buffer
// and replays the previous line twice at the VGA pixel rate.
module video_vga_dbl #(
  parameter int LINE_LEN = 448,
  parameter int ADDR_W   = 9,
  parameter int HS_LEN   = 52
) (
  input logic clk,
  input logic rst,
  video_vga_dbl_if.slave bus
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LINE_LEN - 1);
  localparam logic [ADDR_W-1:0] FULL = ADDR_W'(LINE_LEN);
  localparam int HW = $clog2(HS_LEN + 1);
  typedef enum logic [1:0] {IDLE, PASS0, PASS1} state_t;
  state_t state, state_nx;
  logic [5:0] mem [2**(ADDR_W+1)];
  logic wbank, rbank, seen, valid, we, rd, at0, last, pass_nx;
  logic [ADDR_W-1:0] waddr, raddr, raddr_nx;
  logic [ADDR_W:0] wa, ra;
  logic [HW-1:0] hcnt;
  logic [5:0] color;
  logic hsync, vsync, pass;
  assign we = bus.wr_stb && (bus.line_start || waddr < FULL);
  assign wa = bus.line_start ? {~wbank, ADDR_W'(0)} : {wbank, waddr};
  always_ff @(posedge clk)
    if (we) mem[wa] <= bus.color_in;
  // waddr saturates at LINE_LEN so over-long TV lines never wrap onto pixel 0
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wbank <= 1'b0;
      waddr <= '0;
    end else if (bus.line_start) begin
      wbank <= ~wbank;
      waddr <= bus.wr_stb ? ADDR_W'(1) : '0;
    end else if (we) begin
      waddr <= waddr + ADDR_W'(1);
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_nx;
  always_comb begin
    last     = bus.rd_stb && state != IDLE && raddr == LAST;
    state_nx = bus.line_start ? PASS0 : !last ? state : state == PASS0 ? PASS1 : IDLE;
  end
  // line_start reads the bank just completed (current wbank) before it flips
  always_comb begin
    rd       = bus.rd_stb && (bus.line_start || state != IDLE);
    ra       = bus.line_start ? {wbank, ADDR_W'(0)} : {rbank, raddr};
    at0      = rd && (bus.line_start || raddr == '0);
    pass_nx  = !bus.line_start && state == PASS1;
    raddr_nx = bus.line_start ? (bus.rd_stb ? ADDR_W'(1) : '0) :
               last ? '0 : rd ? raddr + ADDR_W'(1) : raddr;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rbank <= 1'b0;
      raddr <= '0;
      seen  <= 1'b0;
      valid <= 1'b0;
      hcnt  <= '0;
      color <= '0;
      hsync <= 1'b0;
      vsync <= 1'b0;
      pass  <= 1'b0;
    end else begin
      raddr <= raddr_nx;
      if (bus.line_start) begin
        rbank <= wbank;
        seen  <= 1'b1;
        valid <= valid | seen;
        vsync <= bus.vsync_in;
      end
      if (rd) begin
        color <= (valid || (bus.line_start && seen)) ? mem[ra] : '0;
        hsync <= at0 || hcnt != '0;
        hcnt  <= at0 ? HW'(HS_LEN - 1) : hcnt != '0 ? hcnt - HW'(1) : hcnt;
        pass  <= pass_nx;
      end else if (bus.rd_stb) begin
        color <= '0;
        hsync <= 1'b0;
        pass  <= 1'b0;
      end
    end
  assign bus.vga_color = color;
  assign bus.vga_hsync = hsync;
  assign bus.vga_vsync = vsync;
  assign bus.vga_pass  = pass;
endmodule

// File: tb/tb_video_vga_dbl.sv
// tb_video_vga_dbl: directed line sequences checked against a small two-bank line model.
module tb_video_vga_dbl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  video_vga_dbl_if bus();
  video_vga_dbl dut (.clk(clk), .rst(rst), .bus(bus.slave));
  int total = 0, bad = 0;
  int wb = 0, rb = 0, nls = 0, ph = 0, wi = 0, k = 0, lid = 0;
  logic [5:0] mem_m [2][512];
  logic vs_exp = 1'b0;
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s line=%0d k=%0d got=%0h exp=%0h", tag, lid, k, got, exp);
    end
  endtask
  function automatic logic [5:0] col(input int id, input int i);
    case (id)
      0, 1:    return i[5:0];
      2:       return i < 448 ? i[5:0] ^ 6'h15 : 6'h3F;
      3:       return 6'(i + 7);
      default: return 6'(i * 5);
    endcase
  endfunction
  task automatic cyc(input bit ls);
    logic [5:0] ec;
    logic eh;
    int idx;
    @(negedge clk);
    bus.line_start = ls;
    bus.wr_stb = (ph % 4 == 0);
    bus.rd_stb = (ph % 2 == 0);
    if (ls) begin
      rb = wb;
      wb ^= 1;
      wi = 0;
      k = 0;
      nls++;
      vs_exp = bus.vsync_in;
    end
    bus.color_in = bus.wr_stb ? col(lid, wi) : 6'h00;
    if (bus.wr_stb) begin
      if (wi < 448) mem_m[wb][wi] = bus.color_in;
      wi++;
    end
    @(posedge clk);
    #1;
    if (bus.rd_stb) begin
      idx = k % 448;
      ec = (k < 896 && nls >= 2) ? mem_m[rb][idx] : 6'h00;
      eh = k < 896 && idx < 52;
      check("color", 8'(bus.vga_color), 8'(ec));
      check("hsync", 8'(bus.vga_hsync), 8'(eh));
      check("vsync", 8'(bus.vga_vsync), 8'(vs_exp));
      if (k < 896) check("pass", 8'(bus.vga_pass), 8'(k >= 448));
      k++;
    end
    ph++;
  endtask
  task automatic line(input int id, input int n, input int vs_at);
    lid = id;
    for (int i = 0; i < 4 * n; i++) begin
      if (i == vs_at) bus.vsync_in = ~bus.vsync_in;
      cyc(i == 0);
    end
  endtask
  initial begin
    bus.wr_stb = 1'b0;
    bus.rd_stb = 1'b0;
    bus.line_start = 1'b0;
    bus.vsync_in = 1'b0;
    bus.color_in = 6'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_color", 8'(bus.vga_color), 8'h00);
    check("rst_hsync", 8'(bus.vga_hsync), 8'h00);
    check("rst_vsync", 8'(bus.vga_vsync), 8'h00);
    check("rst_pass",  8'(bus.vga_pass),  8'h00);
    @(negedge clk);
    rst = 1'b0;
    line(0, 448, -1);
    line(1, 448, -1);
    line(2, 460, -1);
    line(3, 374, -1);
    line(4, 600, 900);
    line(5, 300, -1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_color", 8'(bus.vga_color), 8'h00);
    check("arst_hsync", 8'(bus.vga_hsync), 8'h00);
    check("arst_vsync", 8'(bus.vga_vsync), 8'h00);
    check("arst_pass",  8'(bus.vga_pass),  8'h00);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
